// File: rtl/bounded_step_counter.sv
// Bounded step counter with STOP / WRAP / BOUNCE run modes and a latched run configuration.
// BOUNCE mode is compiled in only when BOUNDED_STEP_COUNTER_BOUNCE_EN is defined; otherwise mode 10 acts as STOP.
module bounded_step_counter #(
    parameter int Bits     = 8,
    parameter int StepBits = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                load_i,
    input  logic [Bits-1:0]     start_val_i,
    input  logic [Bits-1:0]     end_val_i,
    input  logic [StepBits-1:0] step_i,
    input  logic [1:0]          mode_i,
    output logic [Bits-1:0]     count_o,
    output logic                dir_o,
    output logic                done_o,
    output logic                wrap_o
);

    typedef enum logic [1:0] {
        MODE_STOP   = 2'b00,
        MODE_WRAP   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    logic [Bits-1:0]     start_q, start_d;
    logic [Bits-1:0]     end_q, end_d;
    logic [StepBits-1:0] step_q, step_d;
    mode_e               mode_q, mode_d;
    logic [Bits-1:0]     count_q, count_d;
    logic                done_q, done_d;
    logic                wrap_q, wrap_d;

    logic [Bits:0]       step_ext;
    logic [Bits:0]       up_sum;
    logic [Bits-1:0]     up_next;

    // One extra bit of headroom so count+step never overflows before clamping to the bound.
    assign step_ext = (Bits+1)'(step_q);
    assign up_sum   = {1'b0, count_q} + step_ext;
    assign up_next  = (up_sum >= {1'b0, end_q}) ? end_q : up_sum[Bits-1:0];

`ifdef BOUNDED_STEP_COUNTER_BOUNCE_EN
    logic            dir_q, dir_d;
    logic [Bits:0]   dn_diff;
    logic [Bits-1:0] dn_next;

    // A set top bit means the subtraction borrowed, i.e. count-step went below zero.
    assign dn_diff = {1'b0, count_q} - step_ext;
    assign dn_next = (dn_diff[Bits] || (dn_diff[Bits-1:0] < start_q)) ? start_q : dn_diff[Bits-1:0];
`endif

    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        step_d  = step_q;
        mode_d  = mode_q;
        count_d = count_q;
        done_d  = done_q;
        wrap_d  = 1'b0;
`ifdef BOUNDED_STEP_COUNTER_BOUNCE_EN
        dir_d   = dir_q;
`endif
        if (load_i) begin
            start_d = start_val_i;
            end_d   = end_val_i;
            step_d  = (step_i == '0) ? StepBits'(1) : step_i;
            mode_d  = mode_e'(mode_i);
            count_d = start_val_i;
            done_d  = (start_val_i > end_val_i);
`ifdef BOUNDED_STEP_COUNTER_BOUNCE_EN
            dir_d   = 1'b1;
`endif
        end else if (en_i && !done_q) begin
            case (mode_q)
                MODE_WRAP: begin
                    if (count_q == end_q) begin
                        count_d = start_q;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = up_next;
                    end
                end
`ifdef BOUNDED_STEP_COUNTER_BOUNCE_EN
                MODE_BOUNCE: begin
                    // A zero-length range has nowhere to bounce to, so the count simply holds.
                    if (start_q != end_q) begin
                        if (dir_q) begin
                            if (count_q < end_q) begin
                                count_d = up_next;
                            end else begin
                                dir_d   = 1'b0;
                                count_d = dn_next;
                                wrap_d  = 1'b1;
                            end
                        end else begin
                            if (count_q > start_q) begin
                                count_d = dn_next;
                            end else begin
                                dir_d   = 1'b1;
                                count_d = up_next;
                                wrap_d  = 1'b1;
                            end
                        end
                    end
                end
`endif
                default: begin
                    count_d = up_next;
                    done_d  = (up_next == end_q);
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_q <= '0;
            end_q   <= '0;
            step_q  <= StepBits'(1);
            mode_q  <= MODE_STOP;
            count_q <= '0;
            done_q  <= 1'b1;
            wrap_q  <= 1'b0;
`ifdef BOUNDED_STEP_COUNTER_BOUNCE_EN
            dir_q   <= 1'b1;
`endif
        end else begin
            start_q <= start_d;
            end_q   <= end_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
`ifdef BOUNDED_STEP_COUNTER_BOUNCE_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign count_o = count_q;
    assign done_o  = done_q;
    assign wrap_o  = wrap_q;
`ifdef BOUNDED_STEP_COUNTER_BOUNCE_EN
    assign dir_o   = dir_q;
`else
    assign dir_o   = 1'b1;
`endif

endmodule

// File: tb/tb_bounded_step_counter.sv
// Scoreboard bench for bounded_step_counter: an integer-arithmetic reference model queues
// the expected outputs per cycle and a negedge monitor pops and compares them.
module tb_bounded_step_counter;

    localparam int Bits     = 8;
    localparam int StepBits = 4;
`ifdef BOUNDED_STEP_COUNTER_BOUNCE_EN
    localparam bit BounceOn = 1'b1;
`else
    localparam bit BounceOn = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_i = 1'b0;
    logic                en_i = 1'b0;
    logic                load_i = 1'b0;
    logic [Bits-1:0]     start_val_i = '0;
    logic [Bits-1:0]     end_val_i = '0;
    logic [StepBits-1:0] step_i = '0;
    logic [1:0]          mode_i = '0;
    logic [Bits-1:0]     count_o;
    logic                dir_o;
    logic                done_o;
    logic                wrap_o;

    bounded_step_counter #(.Bits(Bits), .StepBits(StepBits)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .load_i     (load_i),
        .start_val_i(start_val_i),
        .end_val_i  (end_val_i),
        .step_i     (step_i),
        .mode_i     (mode_i),
        .count_o    (count_o),
        .dir_o      (dir_o),
        .done_o     (done_o),
        .wrap_o     (wrap_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit dir;
        bit done;
        bit wrap;
        int tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_n  = 0;

    // Reference run state, kept as plain integers.
    int m_count, m_start, m_end, m_step, m_mode;
    bit m_dir, m_done, m_wrap;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_update(bit rst, bit load, bit en, int sv, int ev, int st, int md);
        m_wrap = 1'b0;
        if (rst) begin
            m_count = 0; m_dir = 1'b1; m_done = 1'b1;
            m_start = 0; m_end = 0; m_step = 1; m_mode = 0;
        end else if (load) begin
            m_start = sv; m_end = ev; m_step = (st == 0) ? 1 : st; m_mode = md;
            m_count = sv; m_dir = 1'b1; m_done = (sv > ev);
        end else if (en && !m_done) begin
            if (m_mode == 1) begin
                if (m_count == m_end) begin
                    m_count = m_start;
                    m_wrap  = 1'b1;
                end else begin
                    m_count = imin(m_count + m_step, m_end);
                end
            end else if (m_mode == 2 && BounceOn) begin
                if (m_start != m_end) begin
                    if (m_dir) begin
                        if (m_count < m_end) m_count = imin(m_count + m_step, m_end);
                        else begin
                            m_dir = 1'b0; m_wrap = 1'b1;
                            m_count = imax(m_count - m_step, m_start);
                        end
                    end else begin
                        if (m_count > m_start) m_count = imax(m_count - m_step, m_start);
                        else begin
                            m_dir = 1'b1; m_wrap = 1'b1;
                            m_count = imin(m_count + m_step, m_end);
                        end
                    end
                end
            end else begin
                m_count = imin(m_count + m_step, m_end);
                if (m_count == m_end) m_done = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, queue the model's post-edge expectation, and advance.
    task automatic apply(bit rst, bit load, bit en, int sv, int ev, int st, int md);
        exp_t e;
        rst_i       = rst;
        load_i      = load;
        en_i        = en;
        start_val_i = Bits'(sv);
        end_val_i   = Bits'(ev);
        step_i      = StepBits'(st);
        mode_i      = 2'(md);
        model_update(rst, load, en, sv, ev, st, md);
        e.count = m_count; e.dir = m_dir; e.done = m_done; e.wrap = m_wrap; e.tag = tag_n;
        tag_n++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_noise(bit en);
        apply(1'b0, 1'b0, en, $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 15), $urandom_range(0, 3));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (int'(count_o) != e.count || dir_o != e.dir || done_o != e.done || wrap_o != e.wrap) begin
                errors++;
                $display("FAIL cycle%0d: got count=%0d dir=%0b done=%0b wrap=%0b, expected count=%0d dir=%0b done=%0b wrap=%0b",
                         e.tag, count_o, dir_o, done_o, wrap_o, e.count, e.dir, e.done, e.wrap);
            end
        end
    end

    initial begin
        // Reset, then enable with no run loaded: nothing moves.
        apply(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        repeat (5) idle_noise(1'b1);

        // Full-range STOP run up to the top of the count width.
        apply(1'b0, 1'b1, 1'b0, 0, 255, 1, 0);
        repeat (258) apply(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);

        // WRAP run.
        apply(1'b0, 1'b1, 1'b1, 10, 20, 4, 1);
        repeat (5) apply(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);

        // BOUNCE run (acts as STOP without the bounce macro).
        apply(1'b0, 1'b1, 1'b0, 50, 56, 3, 2);
        repeat (6) apply(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);

        // BOUNCE with a zero-length range, and reserved mode.
        apply(1'b0, 1'b1, 1'b0, 77, 77, 5, 2);
        repeat (3) apply(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        apply(1'b0, 1'b1, 1'b0, 240, 250, 7, 3);
        repeat (4) apply(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);

        // STOP with enable toggling and the configuration inputs changing underneath.
        apply(1'b0, 1'b1, 1'b0, 50, 100, 1, 0);
        for (int i = 0; i < 100; i++) idle_noise(i[0] == 1'b0);

        // Reset mid-run wins over load and enable; then a run with start above end.
        apply(1'b0, 1'b1, 1'b0, 0, 100, 3, 0);
        repeat (10) apply(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        apply(1'b1, 1'b1, 1'b1, 5, 9, 2, 1);
        repeat (2) idle_noise(1'b1);
        apply(1'b0, 1'b1, 1'b0, 40, 20, 1, 0);
        repeat (3) apply(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);

        // Randomized runs, including zero steps, ranges near the top and occasional resets.
        for (int i = 0; i < 400; i++) begin
            int r, sv, ev;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                apply(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, 0);
            end else if (r < 10) begin
                sv = (r < 5) ? $urandom_range(200, 255) : $urandom_range(0, 220);
                ev = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : imin(sv + $urandom_range(0, 40), 255);
                apply(1'b0, 1'b1, $urandom_range(0, 1), sv, ev, $urandom_range(0, 15), $urandom_range(0, 3));
            end else begin
                idle_noise($urandom_range(0, 3) != 0);
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
